branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_pkg.sv | 26 ++
 rtl/branch_resolve_unit_cond_check.sv | 41 ++++
 rtl/branch_resolve_unit.sv | 94 +++++++++
 tb/tb_branch_resolve_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: ARM condition codes and FSM state encoding.
package branch_resolve_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_cond_check.sv
// Purely combinational ARM condition evaluator: cond field and {N,Z,C,V} -> pass.
import branch_resolve_unit_pkg::*;

module cond_check (
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       cond_pass_o
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = nzcv_i[3];
  assign z_s = nzcv_i[2];
  assign c_s = nzcv_i[1];
  assign v_s = nzcv_i[0];

  // Condition decode
  always_comb begin
    cond_pass_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_pass_o = z_s;
      COND_NE: cond_pass_o = ~z_s;
      COND_CS: cond_pass_o = c_s;
      COND_CC: cond_pass_o = ~c_s;
      COND_MI: cond_pass_o = n_s;
      COND_PL: cond_pass_o = ~n_s;
      COND_VS: cond_pass_o = v_s;
      COND_VC: cond_pass_o = ~v_s;
      COND_HI: cond_pass_o = c_s & ~z_s;
      COND_LS: cond_pass_o = ~c_s | z_s;
      COND_GE: cond_pass_o = (n_s == v_s);
      COND_LT: cond_pass_o = (n_s != v_s);
      COND_GT: cond_pass_o = ~z_s & (n_s == v_s);
      COND_LE: cond_pass_o = z_s | (n_s != v_s);
      COND_AL: cond_pass_o = 1'b1;
      COND_NV: cond_pass_o = 1'b0;
      default: cond_pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EXE-stage branch resolution: condition check, target computation, one-cycle squash
// after a taken branch, NZCV status register and a saturating taken-branch counter.
import branch_resolve_unit_pkg::*;

module branch_resolve_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [3:0]            cond_in,
  input  logic [23:0]           imm24_in,
  input  logic [3:0]            alu_nzcv_in,
  output logic                  Branch_taken,
  output logic [DATA_WIDTH-1:0] BranchAddr,
  output logic                  exec_en,
  output logic [3:0]            status_out,
  output logic [CNT_WIDTH-1:0]  taken_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  bru_state_e            state_q, state_d;
  logic [3:0]            status_q, status_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  cond_pass;
  logic                  live;
  logic [DATA_WIDTH-1:0] offset;

  // Conditions are evaluated against the committed flags, not this cycle's ALU result
  cond_check u_cond_check (
    .cond_i      (cond_in),
    .nzcv_i      (status_q),
    .cond_pass_o (cond_pass)
  );

  assign offset      = {{(DATA_WIDTH-26){imm24_in[23]}}, imm24_in, 2'b00};
  assign BranchAddr  = pc_in + offset;
  assign status_out  = status_q;
  assign taken_count = count_q;

  // Issue gating, next-state, flag and counter updates
  always_comb begin
    live         = valid_in & (state_q == ST_RUN);
    exec_en      = live & cond_pass;
    Branch_taken = exec_en & b_in;
    state_d      = ST_RUN;
    status_d     = status_q;
    count_d      = count_q;

    case (state_q)
      ST_RUN: begin
        if (Branch_taken) begin
          state_d = ST_SQUASH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SQUASH: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if (exec_en & s_in) begin
      status_d = alu_nzcv_in;
    end else begin
      status_d = status_q;
    end

    if (Branch_taken && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // State, flag and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      status_q <= 4'b0000;
      count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus random traffic,
// expected responses from a flag/condition reference model queued per cycle.
module tb_branch_resolve_unit;

  localparam int DW    = 32;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] pc_in;
  logic          b_in;
  logic          s_in;
  logic [3:0]    cond_in;
  logic [23:0]   imm24_in;
  logic [3:0]    alu_nzcv_in;
  logic          Branch_taken;
  logic [DW-1:0] BranchAddr;
  logic          exec_en;
  logic [3:0]    status_out;
  logic [CW-1:0] taken_count;

  branch_resolve_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .pc_in       (pc_in),
    .b_in        (b_in),
    .s_in        (s_in),
    .cond_in     (cond_in),
    .imm24_in    (imm24_in),
    .alu_nzcv_in (alu_nzcv_in),
    .Branch_taken(Branch_taken),
    .BranchAddr  (BranchAddr),
    .exec_en     (exec_en),
    .status_out  (status_out),
    .taken_count (taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          taken;
    logic [31:0] addr;
    bit          exec;
    logic [3:0]  status;
    int          count;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  // Reference model state
  bit   m_squash_next = 1'b0;
  bit   mN = 1'b0, mZ = 1'b0, mC = 1'b0, mV = 1'b0;
  int   m_count = 0;

  function automatic bit cond_holds(input int c, input bit n, input bit z, input bit cf, input bit v);
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cf;
      3:  return !cf;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cf && !z;
      9:  return !cf || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit r, input bit v, input logic [31:0] pc, input bit b, input bit s,
                       input logic [3:0] c, input logic [23:0] imm, input logic [3:0] nzcv);
    exp_t e;
    int   off;
    bit   ex;
    @(posedge clk);
    #1;
    rst = r; valid_in = v; pc_in = pc; b_in = b; s_in = s;
    cond_in = c; imm24_in = imm; alu_nzcv_in = nzcv;
    cyc++;
    if (r) begin
      m_squash_next = 1'b0; mN = 0; mZ = 0; mC = 0; mV = 0; m_count = 0;
    end
    off = int'($signed({imm, 8'h00})) >>> 8;
    ex = v && !m_squash_next && cond_holds(int'(c), mN, mZ, mC, mV);
    e.cyc    = cyc;
    e.exec   = ex;
    e.taken  = ex && b;
    e.addr   = pc + 32'(off * 4);
    e.status = {mN, mZ, mC, mV};
    e.count  = m_count;
    exp_q.push_back(e);
    if (!r) begin
      if (ex && s) {mN, mZ, mC, mV} = nzcv;
      if (e.taken && m_count < CMAX) m_count++;
      m_squash_next = e.taken;
    end
  endtask

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, c, act, expv);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("Branch_taken", e.cyc, 32'(Branch_taken), 32'(e.taken));
        check("BranchAddr",   e.cyc, BranchAddr, e.addr);
        check("exec_en",      e.cyc, 32'(exec_en), 32'(e.exec));
        check("status_out",   e.cyc, 32'(status_out), 32'(e.status));
        check("taken_count",  e.cyc, 32'(taken_count), 32'(e.count));
      end
    end
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; pc_in = '0; b_in = 1'b0; s_in = 1'b0;
    cond_in = 4'h0; imm24_in = '0; alu_nzcv_in = 4'h0;

    // Reset, including a live AL instruction while rst is held
    drive(1, 0, 32'h0, 0, 0, 4'hE, 24'h0, 4'h0);
    drive(1, 1, 32'h100, 0, 1, 4'hE, 24'h000010, 4'hF);
    // Taken AL branch, then killed flag-setter
    drive(0, 1, 32'h0000_0010, 1, 0, 4'hE, 24'h000003, 4'h0);
    drive(0, 1, 32'h0000_0014, 0, 1, 4'hE, 24'h000000, 4'hF);
    // CMP sets Z, then BEQ taken with negative offset to zero
    drive(0, 1, 32'h0000_0018, 0, 1, 4'hE, 24'h000000, 4'b0100);
    drive(0, 1, 32'h0000_0008, 1, 0, 4'h0, 24'hFFFFFE, 4'h0);
    drive(0, 0, 32'h0000_0000, 0, 0, 4'hE, 24'h000000, 4'h0);
    drive(0, 1, 32'h0000_0020, 1, 0, 4'h1, 24'h000004, 4'h0);
    // Wrapping target, back-to-back AL branch killed, ADD live
    drive(0, 1, 32'hFFFF_FFFC, 1, 0, 4'hE, 24'h000001, 4'h0);
    drive(0, 1, 32'h0000_0004, 1, 0, 4'hE, 24'h000005, 4'h0);
    drive(0, 1, 32'h0000_0008, 0, 1, 4'hE, 24'h000000, 4'b0010);
    drive(0, 0, 32'h0000_000C, 1, 0, 4'hE, 24'h000007, 4'h0);
    drive(0, 1, 32'h0000_0010, 0, 0, 4'hF, 24'h000000, 4'h0);
    // Counter saturation
    for (int i = 0; i < CMAX + 4; i++) begin
      drive(0, 1, 32'(i * 8), 1, 0, 4'hE, 24'(i), 4'h0);
      drive(0, 1, 32'(i * 8 + 4), 0, 0, 4'hE, 24'h0, 4'h0);
    end
    // Reset in the middle of a squash, then a live branch right after release
    drive(0, 1, 32'h0000_0040, 0, 1, 4'hE, 24'h0, 4'b1001);
    drive(0, 1, 32'h0000_0044, 1, 0, 4'hE, 24'h000002, 4'h0);
    drive(1, 0, 32'h0000_0048, 0, 0, 4'hE, 24'h0, 4'h0);
    drive(0, 1, 32'h0000_0050, 1, 0, 4'hE, 24'h000001, 4'h0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0), $urandom(),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
            4'($urandom_range(0, 15)), 24'($urandom()), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
